// File: rtl/axi_rdata_arbiter.sv
// Purpose: AXI read-data arbiter from three sources (S0, S1, default slave DS) to two masters (M0, M1), routed by the RID master tag.
// Latency: one arbitration cycle in IDLE, then one beat per cycle through a registered-select mux with no data storage.
// Backpressure: the granted slave's RReady follows the tagged master's RReady; beats with a bad tag drain at full rate.
// Build option RDATA_ARB_RR_EN: round-robin arbitration starting at rr_ptr. Left undefined: fixed priority DS > S1 > S0.
module axi_rdata_arbiter #(
  parameter int SID_BITS  = 8,
  parameter int MID_BITS  = 4,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [SID_BITS-1:0]  S0_RID,
  input  logic [DATA_BITS-1:0] S0_RData,
  input  logic [1:0]           S0_RResp,
  input  logic                 S0_RLast,
  input  logic                 S0_RValid,
  output logic                 S0_RReady,

  input  logic [SID_BITS-1:0]  S1_RID,
  input  logic [DATA_BITS-1:0] S1_RData,
  input  logic [1:0]           S1_RResp,
  input  logic                 S1_RLast,
  input  logic                 S1_RValid,
  output logic                 S1_RReady,

  input  logic [SID_BITS-1:0]  DS_RID,
  input  logic [DATA_BITS-1:0] DS_RData,
  input  logic [1:0]           DS_RResp,
  input  logic                 DS_RLast,
  input  logic                 DS_RValid,
  output logic                 DS_RReady,

  output logic [MID_BITS-1:0]  M0_RID,
  output logic [DATA_BITS-1:0] M0_RData,
  output logic [1:0]           M0_RResp,
  output logic                 M0_RLast,
  output logic                 M0_RValid,
  input  logic                 M0_RReady,

  output logic [MID_BITS-1:0]  M1_RID,
  output logic [DATA_BITS-1:0] M1_RData,
  output logic [1:0]           M1_RResp,
  output logic                 M1_RLast,
  output logic                 M1_RValid,
  input  logic                 M1_RReady,

  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  // The master tag sits in the top four bits of the slave-side RID.
  localparam int TAG_LSB = SID_BITS - 4;
  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

  // One slave R beat as a single bus; bit 0 = S0, bit 1 = S1, bit 2 = DS in all one-hot vectors below.
  typedef struct packed {
    logic [SID_BITS-1:0]  id;
    logic [DATA_BITS-1:0] dat;
    logic [1:0]           resp;
    logic                 last;
  } r_beat_t;

  typedef enum logic {IDLE, BURST} state_t;

  r_beat_t     s_beat [3];
  logic [2:0]  s_vld;
  logic [2:0]  s_rdy;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  win;

  r_beat_t     g_beat;
  logic        g_vld;
  logic        g_rdy;
  logic [3:0]  g_tag;
  logic        route_m0;
  logic        route_m1;
  logic        drain;
  logic        hs;
  logic        burst_end;

  assign s_beat[0] = {S0_RID, S0_RData, S0_RResp, S0_RLast};
  assign s_beat[1] = {S1_RID, S1_RData, S1_RResp, S1_RLast};
  assign s_beat[2] = {DS_RID, DS_RData, DS_RResp, DS_RLast};
  assign s_vld     = {DS_RValid, S1_RValid, S0_RValid};

  assign S0_RReady = s_rdy[0];
  assign S1_RReady = s_rdy[1];
  assign DS_RReady = s_rdy[2];

`ifdef RDATA_ARB_RR_EN
  // One-hot pointer to the slave searched first; it moves to the slave after the one just served.
  logic [2:0] rr_ptr_q;

  // Pointer advances only when a burst completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= 3'b001;
    end else if (burst_end) begin
      rr_ptr_q <= {grant_q[1:0], grant_q[2]};
    end
  end

  // Round-robin pick: search S0 -> S1 -> DS, starting at rr_ptr and wrapping.
  always_comb begin
    win = 3'b000;
    case (rr_ptr_q)
      3'b010: begin
        if      (s_vld[1]) win = 3'b010;
        else if (s_vld[2]) win = 3'b100;
        else if (s_vld[0]) win = 3'b001;
      end
      3'b100: begin
        if      (s_vld[2]) win = 3'b100;
        else if (s_vld[0]) win = 3'b001;
        else if (s_vld[1]) win = 3'b010;
      end
      default: begin
        if      (s_vld[0]) win = 3'b001;
        else if (s_vld[1]) win = 3'b010;
        else if (s_vld[2]) win = 3'b100;
      end
    endcase
  end
`else
  // Fixed-priority pick: the default slave first, then S1, then S0.
  always_comb begin
    win = 3'b000;
    if      (s_vld[2]) win = 3'b100;
    else if (s_vld[1]) win = 3'b010;
    else if (s_vld[0]) win = 3'b001;
  end
`endif

  // Select the granted slave's channel; an empty grant yields an all-zero beat.
  always_comb begin
    g_beat = '0;
    g_vld  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q[i]) begin
        g_beat = s_beat[i];
        g_vld  = s_vld[i];
      end
    end
  end

  // The tag is decoded on every beat, so a tag change mid-burst re-steers the burst.
  always_comb begin
    g_tag     = g_beat.id[SID_BITS-1:TAG_LSB];
    route_m0  = (g_tag == TAG_M0);
    route_m1  = (g_tag == TAG_M1);
    drain     = !route_m0 && !route_m1;
    g_rdy     = route_m0 ? M0_RReady : (route_m1 ? M1_RReady : 1'b1);
    hs        = (state_q == BURST) && g_vld && g_rdy;
    burst_end = hs && g_beat.last;
  end

  // State and grant registers; reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next state: arbitrate in IDLE; hold the grant until the last beat handshakes.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|s_vld) begin
          state_d = BURST;
          grant_d = win;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_d = IDLE;
          grant_d = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // Outputs: payload goes to both masters during BURST; only RValid and the slave RReady are steered.
  always_comb begin
    M0_RValid = 1'b0;
    M1_RValid = 1'b0;
    s_rdy     = 3'b000;
    M0_RID    = '0;
    M1_RID    = '0;
    M0_RData  = '0;
    M1_RData  = '0;
    M0_RResp  = 2'b00;
    M1_RResp  = 2'b00;
    M0_RLast  = 1'b0;
    M1_RLast  = 1'b0;
    busy      = 1'b0;
    if (state_q == BURST) begin
      busy      = 1'b1;
      M0_RValid = g_vld && route_m0;
      M1_RValid = g_vld && route_m1;
      s_rdy     = grant_q & {3{g_rdy}};
      M0_RID    = g_beat.id[MID_BITS-1:0];
      M1_RID    = g_beat.id[MID_BITS-1:0];
      M0_RData  = g_beat.dat;
      M1_RData  = g_beat.dat;
      M0_RResp  = g_beat.resp;
      M1_RResp  = g_beat.resp;
      M0_RLast  = g_beat.last;
      M1_RLast  = g_beat.last;
    end
  end

  // Count drained beats, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= 8'd0;
    end else if (hs && drain && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // The grant is either empty or names exactly one slave.
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));

endmodule

// File: tb/tb_axi_rdata_arbiter.sv
// Bench for axi_rdata_arbiter: cycle tables, hand-written corner sequences and a random run against a reference model.
module tb_axi_rdata_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  s_rid  [3];
  logic [31:0] s_dat  [3];
  logic [1:0]  s_resp [3];
  logic        s_last [3];
  logic        s_vld  [3];
  logic        s_rdy  [3];
  logic        m0_rdy, m1_rdy;
  logic [3:0]  m0_id, m1_id;
  logic [31:0] m0_dat, m1_dat;
  logic [1:0]  m0_resp, m1_resp;
  logic        m0_last, m1_last, m0_vld, m1_vld;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rdata_arbiter dut (
    .clk(clk), .rst(rst),
    .S0_RID(s_rid[0]), .S0_RData(s_dat[0]), .S0_RResp(s_resp[0]), .S0_RLast(s_last[0]),
    .S0_RValid(s_vld[0]), .S0_RReady(s_rdy[0]),
    .S1_RID(s_rid[1]), .S1_RData(s_dat[1]), .S1_RResp(s_resp[1]), .S1_RLast(s_last[1]),
    .S1_RValid(s_vld[1]), .S1_RReady(s_rdy[1]),
    .DS_RID(s_rid[2]), .DS_RData(s_dat[2]), .DS_RResp(s_resp[2]), .DS_RLast(s_last[2]),
    .DS_RValid(s_vld[2]), .DS_RReady(s_rdy[2]),
    .M0_RID(m0_id), .M0_RData(m0_dat), .M0_RResp(m0_resp), .M0_RLast(m0_last),
    .M0_RValid(m0_vld), .M0_RReady(m0_rdy),
    .M1_RID(m1_id), .M1_RData(m1_dat), .M1_RResp(m1_resp), .M1_RLast(m1_last),
    .M1_RValid(m1_vld), .M1_RReady(m1_rdy),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int          sel;
    logic        vld;
    logic [7:0]  rid;
    logic [31:0] dat;
    logic        last;
    logic        m0r;
    logic        m1r;
    logic        e_m0v;
    logic        e_m1v;
    logic        e_srdy;
    logic        e_busy;
    logic [3:0]  e_id;
    logic [31:0] e_dat;
    logic        e_last;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs [17];

  // Reference-model state: is a burst open, who owns it, round-robin start, drop count.
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_drop;

  function automatic logic [127:0] pack(logic v0, logic v1, logic [2:0] sr, logic [3:0] id0, logic [3:0] id1,
                                        logic [31:0] d0, logic [31:0] d1, logic [1:0] r0, logic [1:0] r1,
                                        logic l0, logic l1, logic b, logic [7:0] dc);
    return {36'd0, v0, v1, sr, id0, id1, d0, d1, r0, r1, l0, l1, b, dc};
  endfunction

  function automatic logic [127:0] outs();
    return pack(m0_vld, m1_vld, {s_rdy[2], s_rdy[1], s_rdy[0]}, m0_id, m1_id, m0_dat, m1_dat,
                m0_resp, m1_resp, m0_last, m1_last, busy, drop_cnt);
  endfunction

  function automatic vec_t mk(int sel, logic vld, logic [7:0] rid, logic [31:0] dat, logic last,
                              logic m0r, logic m1r, logic e_m0v, logic e_m1v, logic e_srdy, logic e_busy,
                              logic [3:0] e_id, logic [31:0] e_dat, logic e_last, logic [7:0] e_drop);
    vec_t v;
    v.sel = sel; v.vld = vld; v.rid = rid; v.dat = dat; v.last = last; v.m0r = m0r; v.m1r = m1r;
    v.e_m0v = e_m0v; v.e_m1v = e_m1v; v.e_srdy = e_srdy; v.e_busy = e_busy;
    v.e_id = e_id; v.e_dat = e_dat; v.e_last = e_last; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      s_vld[i] = 1'b0; s_rid[i] = 8'h00; s_dat[i] = 32'h0; s_resp[i] = 2'b00; s_last[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [2:0]  esr;
    logic        ev0, ev1, el;
    logic [3:0]  eid, tag;
    logic [31:0] ed;
    logic [1:0]  er;
    int          exp_order [4];
    int          o;
    bit          found;

    idle_inputs();
    m0_rdy = 1'b0;
    m1_rdy = 1'b0;

    // Reset state, observed while reset is held.
    #3 check("reset_state", outs(), 128'd0);
    tick();
    rst = 1'b1;
    tick();

    // Per-cycle tables: S0 4-beat burst to M0, DS bad-tag drain, S1 burst to M1 under toggling ready.
    vecs[0]  = mk(0, 1, 8'h13, 32'hA0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd0);
    vecs[1]  = mk(0, 1, 8'h13, 32'hA0, 0, 1, 0, 1, 0, 1, 1, 4'h3, 32'hA0, 0, 8'd0);
    vecs[2]  = mk(0, 1, 8'h13, 32'hA1, 0, 1, 0, 1, 0, 1, 1, 4'h3, 32'hA1, 0, 8'd0);
    vecs[3]  = mk(0, 1, 8'h13, 32'hA2, 0, 1, 0, 1, 0, 1, 1, 4'h3, 32'hA2, 0, 8'd0);
    vecs[4]  = mk(0, 1, 8'h13, 32'hA3, 1, 1, 0, 1, 0, 1, 1, 4'h3, 32'hA3, 1, 8'd0);
    vecs[5]  = mk(0, 0, 8'h00, 32'h0,  0, 1, 0, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd0);
    vecs[6]  = mk(2, 1, 8'h40, 32'hB0, 0, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd0);
    vecs[7]  = mk(2, 1, 8'h40, 32'hB0, 0, 1, 1, 0, 0, 1, 1, 4'h0, 32'hB0, 0, 8'd0);
    vecs[8]  = mk(2, 1, 8'h40, 32'hB1, 1, 1, 1, 0, 0, 1, 1, 4'h0, 32'hB1, 1, 8'd1);
    vecs[9]  = mk(2, 0, 8'h00, 32'h0,  0, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd2);
    vecs[10] = mk(1, 1, 8'h25, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd2);
    vecs[11] = mk(1, 1, 8'h25, 32'hC0, 0, 0, 1, 0, 1, 1, 1, 4'h5, 32'hC0, 0, 8'd2);
    vecs[12] = mk(1, 1, 8'h25, 32'hC1, 0, 0, 0, 0, 1, 0, 1, 4'h5, 32'hC1, 0, 8'd2);
    vecs[13] = mk(1, 1, 8'h25, 32'hC1, 0, 0, 1, 0, 1, 1, 1, 4'h5, 32'hC1, 0, 8'd2);
    vecs[14] = mk(1, 1, 8'h25, 32'hC2, 1, 0, 0, 0, 1, 0, 1, 4'h5, 32'hC2, 1, 8'd2);
    vecs[15] = mk(1, 1, 8'h25, 32'hC2, 1, 0, 1, 0, 1, 1, 1, 4'h5, 32'hC2, 1, 8'd2);
    vecs[16] = mk(1, 0, 8'h00, 32'h0,  0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0,  0, 8'd2);

    for (int r = 0; r < 17; r++) begin
      idle_inputs();
      s_vld[vecs[r].sel]  = vecs[r].vld;
      s_rid[vecs[r].sel]  = vecs[r].rid;
      s_dat[vecs[r].sel]  = vecs[r].dat;
      s_resp[vecs[r].sel] = 2'b10;
      s_last[vecs[r].sel] = vecs[r].last;
      m0_rdy = vecs[r].m0r;
      m1_rdy = vecs[r].m1r;
      #3;
      check($sformatf("table_row%0d", r), outs(),
            pack(vecs[r].e_m0v, vecs[r].e_m1v, 3'({vecs[r].e_srdy} << vecs[r].sel), vecs[r].e_id, vecs[r].e_id,
                 vecs[r].e_dat, vecs[r].e_dat, vecs[r].e_busy ? 2'b10 : 2'b00, vecs[r].e_busy ? 2'b10 : 2'b00,
                 vecs[r].e_last, vecs[r].e_last, vecs[r].e_busy, vecs[r].e_drop));
      tick();
    end

    // Contention: all three slaves hold single-beat bursts to M1.
    do_reset();
`ifdef RDATA_ARB_RR_EN
    exp_order = '{0, 1, 2, 0};
`else
    exp_order = '{2, 2, 2, 2};
`endif
    for (int i = 0; i < 3; i++) begin
      s_vld[i] = 1'b1; s_rid[i] = 8'h20 + 8'(i); s_dat[i] = 32'hD0 + 32'(i); s_last[i] = 1'b1;
    end
    m0_rdy = 1'b0;
    m1_rdy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #3 check($sformatf("cont_idle%0d", b), {busy, s_rdy[2], s_rdy[1], s_rdy[0]}, 128'd0);
      tick();
      #3 check($sformatf("cont_grant%0d", b), {s_rdy[2], s_rdy[1], s_rdy[0], m1_vld, m0_vld, m1_id},
               {3'(3'b001 << exp_order[b]), 1'b1, 1'b0, 4'(exp_order[b])});
      tick();
    end

    // Saturation: 300 single-beat bad-tag bursts from S0.
    idle_inputs();
    s_vld[0] = 1'b1; s_rid[0] = 8'h00; s_last[0] = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      tick();
      if (n == 254) check("sat_254", drop_cnt, 8'd254);
      if (n == 255) check("sat_255", drop_cnt, 8'd255);
    end
    check("sat_300", drop_cnt, 8'd255);
    idle_inputs();
    tick();

    // Reset asserted on beat 2 of a 4-beat S0 burst, between clock edges.
    s_vld[0] = 1'b1; s_rid[0] = 8'h13; s_dat[0] = 32'hE0; s_last[0] = 1'b0;
    m0_rdy = 1'b1;
    tick();
    tick();
    s_dat[0] = 32'hE1;
    #1 check("rst_pre_busy", {busy, s_rdy[0], m0_vld}, 3'b111);
    #1 rst = 1'b0;
    #1 check("rst_async", outs(), 128'd0);
    idle_inputs();
    tick();
    #2 rst = 1'b1;
    tick();
    s_vld[0] = 1'b1; s_rid[0] = 8'h11; s_dat[0] = 32'hF0; s_last[0] = 1'b1;
    #3 check("post_rst_arb", {busy, s_rdy[0], m0_vld}, 3'b000);
    tick();
    #3 check("post_rst_beat", {busy, s_rdy[0], m0_vld, m0_id, m0_dat}, {3'b111, 4'h1, 32'hF0});
    tick();
    idle_inputs();
    tick();

    // Random traffic against the reference model.
    do_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_drop = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        int t;
        t = $urandom_range(0, 7);
        s_vld[i]  = ($urandom_range(0, 3) != 0);
        s_rid[i]  = {(t < 3) ? 4'h1 : (t < 6) ? 4'h2 : (t == 6) ? 4'h0 : 4'hF, 4'($urandom_range(0, 15))};
        s_dat[i]  = $urandom;
        s_resp[i] = 2'($urandom_range(0, 3));
        s_last[i] = ($urandom_range(0, 2) == 0);
      end
      m0_rdy = ($urandom_range(0, 3) != 0);
      m1_rdy = ($urandom_range(0, 3) != 0);

      ev0 = 0; ev1 = 0; esr = 3'b000; eid = 4'h0; ed = 32'h0; er = 2'b00; el = 0; tag = 4'h0;
      if (m_busy) begin
        o   = m_owner;
        tag = s_rid[o][7:4];
        eid = s_rid[o][3:0]; ed = s_dat[o]; er = s_resp[o]; el = s_last[o];
        if (tag == 4'h1) begin
          ev0 = s_vld[o]; esr[o] = m0_rdy;
        end else if (tag == 4'h2) begin
          ev1 = s_vld[o]; esr[o] = m1_rdy;
        end else begin
          esr[o] = 1'b1;
        end
      end
      #3 check($sformatf("random_c%0d", c), outs(),
               pack(ev0, ev1, esr, eid, eid, ed, ed, er, er, el, el, m_busy, 8'(m_drop)));

      if (!m_busy) begin
        found = 0;
`ifdef RDATA_ARB_RR_EN
        for (int k = 0; k < 3; k++) begin
          if (!found && s_vld[(m_rr + k) % 3]) begin
            found = 1; m_owner = (m_rr + k) % 3;
          end
        end
`else
        for (int k = 2; k >= 0; k--) begin
          if (!found && s_vld[k]) begin
            found = 1; m_owner = k;
          end
        end
`endif
        if (found) m_busy = 1;
      end else if (s_vld[m_owner] && esr[m_owner]) begin
        if (tag != 4'h1 && tag != 4'h2 && m_drop < 255) m_drop++;
        if (s_last[m_owner]) begin
          m_busy = 0;
          m_rr = (m_owner + 1) % 3;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rdata_arbiter.md
Name: axi_rdata_arbiter

Overview:
- Registered read-data-channel arbiter between three read-data sources (S0, S1, default slave DS) and two masters (M0, M1).
- Grants one slave at a time and holds the grant for a whole burst, until the RLast beat handshakes.
- Routes the granted slave's R channel to the master encoded in RID[7:4]; strips that field on the way to the master.
- Replaces the purely combinational, priority-only R mux in the AXI interconnect.

Parameters:
- SID_BITS, 8, slave-side RID width; bits [SID_BITS-1:SID_BITS-4] are the master tag.
- MID_BITS, 4, master-side RID width; equals SID_BITS-4.
- DATA_BITS, 32, RData width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- S0_RID/S1_RID/DS_RID  in  SID_BITS  slave read ID, master tag in upper 4 bits.
- S0_RData/S1_RData/DS_RData  in  DATA_BITS  slave read data.
- S0_RResp/S1_RResp/DS_RResp  in  2  slave read response.
- S0_RLast/S1_RLast/DS_RLast  in  1  slave last beat.
- S0_RValid/S1_RValid/DS_RValid  in  1  slave valid.
- S0_RReady/S1_RReady/DS_RReady  out  1  ready back to the slave.
- M0_RID/M1_RID  out  MID_BITS  RID[MID_BITS-1:0] of the granted slave.
- M0_RData/M1_RData  out  DATA_BITS  forwarded data.
- M0_RResp/M1_RResp  out  2  forwarded response.
- M0_RLast/M1_RLast  out  1  forwarded last.
- M0_RValid/M1_RValid  out  1  forwarded valid.
- M0_RReady/M1_RReady  in  1  master ready.
- busy  out  1  high while in BURST.
- drop_cnt  out  8  saturating count of beats drained because of a bad master tag.

Behaviour:
- Reset (rst=0, async): state=IDLE, grant=none, rr_ptr=S0, drop_cnt=0.
  - While in reset, all RValid and RReady outputs are 0, busy=0, and all data/ID/resp/last outputs are 0.
- FSM states: IDLE and BURST.
- IDLE:
  - All RReady=0 and all Mx_RValid=0.
  - If any slave RValid=1, pick a winner with the arbitration policy (see Optional Feature), register grant, and go to BURST.
  - Arbitration costs exactly 1 cycle: the first beat is forwarded in the cycle after RValid is first seen.
- BURST, routing by tag = granted RID[SID_BITS-1:SID_BITS-4]:
  - tag=4'b0001 -> M0.
  - tag=4'b0010 -> M1.
  - Any other tag -> drain.
- BURST, forwarding:
  - Target Mx_RValid = granted slave RValid; the other master's RValid=0.
  - Granted slave RReady = target Mx_RReady. Non-granted slaves see RReady=0.
  - Payload (RID low bits, RData, RResp, RLast) is driven to both masters; only RValid is steered.
- Drain: granted slave RReady=1 and no master sees valid. drop_cnt increments per drained beat and saturates at 255.
- Tag is re-evaluated every beat; a mid-burst tag change follows the new tag.
- Burst end: on granted RValid & RReady & RLast:
  - state goes to IDLE and grant clears;
  - rr_ptr = granted slave + 1, wrapping S0 -> S1 -> DS -> S0.
- Back-to-back bursts: minimum 1 idle cycle between bursts (the IDLE arbitration cycle).
- Granted slave drops RValid mid-burst: this is a protocol violation; grant is held, no beat is forwarded, and no timeout applies.
- Non-granted slaves: their RValid is ignored until the next IDLE.
- Master backpressure (RReady=0): the slave is stalled; the grant, and therefore the slave's payload, is unchanged.
- Reset asserted mid-burst: immediate return to IDLE with outputs as in reset; a partial burst is abandoned.
- The block is pure control. The data path is a registered-select mux with no data storage.

Optional Feature:
- Macro: RDATA_ARB_RR_EN.
- Defined: round-robin. The search starts at rr_ptr, in order S0, S1, DS, wrapping.
- Undefined: fixed priority DS > S1 > S0. rr_ptr is not implemented and has no effect.

Test Plan:
- Single slave: S0 drives a 4-beat burst with RID=8'h13 while M0_RReady=1. M0 gets RID=4'h3 and beats 1 cycle after S0_RValid rises, at 1 beat/cycle. RLast is on beat 4. M1_RValid stays 0 and busy falls after the last beat.
- Contention with RR_EN: S0, S1 and DS are all valid with 1-beat bursts to M1. Grant order is S0, S1, DS, S0. Without RR_EN the order is DS, DS, ... while DS stays valid.
- Backpressure: S1 burst of 3 beats to M1 with M1_RReady toggling 1,0,1,0,1. S1_RReady mirrors M1_RReady, S1 data stays stable while stalled, and the burst completes in 5 cycles.
- Bad tag: DS drives a 2-beat burst with RID=8'h40. DS_RReady=1 for 2 cycles, no master valid, and drop_cnt goes 0 -> 2.
- Saturation: 300 single-beat bad-tag bursts -> drop_cnt=255.
- Reset mid-burst: rst=0 on beat 2 of 4. All valid/ready outputs go 0 without waiting for a clock edge. After release the FSM is in IDLE, and a new S0 burst is granted normally.
